// File: rtl/led_bar_animator.sv
`default_nettype none
// ============================================================================
// Module   : led_bar_animator
// Brief    : LED-bar animation engine. A prescaler paces frames at one of
//            three speeds (or single-steps from a button when stopped), a
//            position counter walks the selected pattern, and a registered
//            frame drives the LED bar directly.
// Revision : 1.0 - initial release
// ============================================================================
module led_bar_animator #(
   parameter int N_LEDS   = 16,
   parameter int DIV_SLOW = 100000000,
   parameter int DIV_MID  = 50000000,
   parameter int DIV_FAST = 20000000,
   parameter int CNT_W    = 27
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        speed,
   input  logic [1:0]        mode,
   input  logic              step,
   output logic [N_LEDS-1:0] frame,
   output logic              frame_tick
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   // pos must reach 2N-1 in fill-bounce mode.
   localparam int POS_W = $clog2(2 * N_LEDS);

   typedef logic [POS_W-1:0] pos_t;

   localparam pos_t POS_ZERO     = '0;
   localparam pos_t POS_ONE      = pos_t'(1);
   localparam pos_t POS_DOT_END  = pos_t'(N_LEDS - 1);
   localparam pos_t POS_FILL_END = pos_t'(2 * N_LEDS - 1);
   localparam pos_t POS_HALF     = pos_t'(N_LEDS);
   // 2N may not fit in POS_W bits (it wraps to 0 when 2N is a power of two);
   // the subtraction 2N - pos is then still exact modulo 2^POS_W.
   localparam pos_t POS_SPAN     = pos_t'(2 * N_LEDS);

   localparam logic [N_LEDS-1:0] ALL_ONES = '1;
   localparam logic [N_LEDS-1:0] LSB_ONE  = N_LEDS'(1);

   localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] RELOAD_SLOW = CNT_W'(DIV_SLOW - 1);
   localparam logic [CNT_W-1:0] RELOAD_MID  = CNT_W'(DIV_MID - 1);
   localparam logic [CNT_W-1:0] RELOAD_FAST = CNT_W'(DIV_FAST - 1);

   localparam logic [1:0] SPEED_STOP = 2'd0;
   localparam logic [1:0] SPEED_SLOW = 2'd1;
   localparam logic [1:0] SPEED_MID  = 2'd2;
   localparam logic [1:0] SPEED_FAST = 2'd3;

   localparam logic [1:0] MODE_FILL  = 2'd0;
   localparam logic [1:0] MODE_DOT   = 2'd1;
   localparam logic [1:0] MODE_PING  = 2'd2;
   localparam logic [1:0] MODE_BLINK = 2'd3;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] count;
   logic [1:0]       speed_q;
   logic [1:0]       mode_q;
   logic             step_q;
   pos_t             pos;
   logic             dir_up;

   // ------------------------------------------------------------------------
   // Next-state signals
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0]  reload;
   logic [CNT_W-1:0]  count_next;
   logic              speed_change;
   logic              mode_change;
   logic              step_rise;
   logic              adv;
   pos_t              pos_next;
   logic              dir_up_next;
   pos_t              ones;
   logic [N_LEDS-1:0] frame_next;

   assign speed_change = (speed != speed_q);
   assign mode_change  = (mode != mode_q);
   assign step_rise    = step & ~step_q;

   // Reload value for the currently requested speed (stop holds at zero).
   always_comb begin
      reload = CNT_ZERO;
      case (speed)
         SPEED_SLOW: reload = RELOAD_SLOW;
         SPEED_MID:  reload = RELOAD_MID;
         SPEED_FAST: reload = RELOAD_FAST;
         default:    reload = CNT_ZERO;
      endcase
   end

   // Prescaler: a speed change restarts a full frame period without advancing;
   // when stopped only a step rising edge advances and the count is held.
   always_comb begin
      count_next = count;
      adv        = 1'b0;
      if (speed_change) begin
         count_next = reload;
      end else if (speed != SPEED_STOP) begin
         if (count == CNT_ZERO) begin
            adv        = 1'b1;
            count_next = reload;
         end else begin
            count_next = count - CNT_ONE;
         end
      end else begin
         adv = step_rise;
      end
   end

   // Position stepping for the active pattern; only used when adv is taken.
   always_comb begin
      pos_next    = pos;
      dir_up_next = dir_up;
      case (mode)
         MODE_FILL: begin
            pos_next = (pos == POS_FILL_END) ? POS_ZERO : pos + POS_ONE;
         end
         MODE_DOT: begin
            pos_next = (pos == POS_DOT_END) ? POS_ZERO : pos + POS_ONE;
         end
         MODE_PING: begin
            // Direction flips as the dot lands on an end, so each end LED is
            // shown for a single frame.
            if (dir_up) begin
               pos_next = pos + POS_ONE;
               if (pos_next == POS_DOT_END) begin
                  dir_up_next = 1'b0;
               end
            end else begin
               pos_next = pos - POS_ONE;
               if (pos_next == POS_ZERO) begin
                  dir_up_next = 1'b1;
               end
            end
         end
         default: begin
            pos_next = (pos == POS_ZERO) ? POS_ONE : POS_ZERO;
         end
      endcase
   end

   // Pattern generator: frame for the position about to be registered.
   always_comb begin
      ones       = (pos_next <= POS_HALF) ? pos_next : (POS_SPAN - pos_next);
      frame_next = '0;
      case (mode)
         MODE_FILL:  frame_next = ~(ALL_ONES >> ones);
         MODE_DOT:   frame_next = LSB_ONE << (POS_DOT_END - pos_next);
         MODE_PING:  frame_next = LSB_ONE << (POS_DOT_END - pos_next);
         MODE_BLINK: frame_next = (pos_next != POS_ZERO) ? ALL_ONES : '0;
         default:    frame_next = '0;
      endcase
   end

   // Previous speed/mode are tracked even during reset so the first cycle
   // after reset does not see a spurious change.
   always_ff @(posedge clk) begin
      speed_q <= speed;
      mode_q  <= mode;
   end

   // Animation state: mode change clears and wins over any advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= CNT_ZERO;
         step_q     <= 1'b0;
         pos        <= POS_ZERO;
         dir_up     <= 1'b1;
         frame      <= '0;
         frame_tick <= 1'b0;
      end else begin
         count  <= count_next;
         step_q <= step;
         if (mode_change) begin
            pos        <= POS_ZERO;
            dir_up     <= 1'b1;
            frame      <= '0;
            frame_tick <= 1'b0;
         end else if (adv) begin
            pos        <= pos_next;
            dir_up     <= dir_up_next;
            frame      <= frame_next;
            frame_tick <= 1'b1;
         end else begin
            frame_tick <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_bar_animator.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_bar_animator
// Brief    : Self-checking bench for led_bar_animator (N_LEDS=4, small
//            dividers). A frame-sequence model is compared every cycle, and
//            directed scenarios pin hand-computed frames and tick spacing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_bar_animator;

   localparam int N = 4;
   localparam int D_SLOW = 8;
   localparam int D_MID  = 4;
   localparam int D_FAST = 2;

   logic         clk;
   logic         rst;
   logic [1:0]   speed;
   logic [1:0]   mode;
   logic         step;
   logic [N-1:0] frame;
   logic         frame_tick;

   int tests = 0;
   int fails = 0;

   led_bar_animator #(
      .N_LEDS   (N),
      .DIV_SLOW (D_SLOW),
      .DIV_MID  (D_MID),
      .DIV_FAST (D_FAST),
      .CNT_W    (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .speed      (speed),
      .mode       (mode),
      .step       (step),
      .frame      (frame),
      .frame_tick (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ------------------------------------------------------------------------
   // Comparison helper
   // ------------------------------------------------------------------------
   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Model: each mode is a fixed cyclic list of frames; an advance moves to
   // the next list entry. Advances are scheduled at absolute cycle numbers.
   // ------------------------------------------------------------------------
   function automatic int seq_len(input logic [1:0] md);
      case (md)
         2'd0:    return 2 * N;
         2'd1:    return N;
         2'd2:    return 2 * N - 2;
         default: return 2;
      endcase
   endfunction

   function automatic int div_of(input logic [1:0] sp);
      case (sp)
         2'd1:    return D_SLOW;
         2'd2:    return D_MID;
         2'd3:    return D_FAST;
         default: return 1;
      endcase
   endfunction

   function automatic logic [N-1:0] pattern(input logic [1:0] md, input int idx);
      logic [N-1:0] f;
      int ones;
      int p;
      f = '0;
      case (md)
         2'd0: begin
            ones = (idx <= N) ? idx : 2 * N - idx;
            for (int i = 0; i < N; i++)
               if (i >= N - ones) f[i] = 1'b1;
         end
         2'd1: f[N-1-idx] = 1'b1;
         2'd2: begin
            p = (idx < N) ? idx : 2 * N - 2 - idx;
            f[N-1-p] = 1'b1;
         end
         default: f = (idx != 0) ? '1 : '0;
      endcase
      return f;
   endfunction

   bit           m_valid = 1'b0;
   int           cyc = 0;
   int           m_idx;
   int           m_next_adv;
   logic [1:0]   m_speed_prev;
   logic [1:0]   m_mode_prev;
   logic         m_step_prev;
   logic [N-1:0] exp_frame;
   logic         exp_tick;

   task automatic model_edge();
      bit adv;
      cyc++;
      if (rst) begin
         m_valid      = 1'b1;
         m_idx        = 0;
         exp_frame    = '0;
         exp_tick     = 1'b0;
         m_step_prev  = 1'b0;
         m_speed_prev = speed;
         m_mode_prev  = mode;
         m_next_adv   = cyc + 1;
      end else begin
         adv = 1'b0;
         if (speed != m_speed_prev) begin
            m_next_adv = cyc + div_of(speed);
         end else if (speed != 2'd0) begin
            if (cyc == m_next_adv) begin
               adv        = 1'b1;
               m_next_adv = cyc + div_of(speed);
            end
         end else begin
            adv = step && !m_step_prev;
         end
         if (mode != m_mode_prev) begin
            m_idx     = 0;
            exp_frame = '0;
            exp_tick  = 1'b0;
         end else if (adv) begin
            m_idx     = (m_idx + 1) % seq_len(mode);
            exp_frame = pattern(mode, m_idx);
            exp_tick  = 1'b1;
         end else begin
            exp_tick = 1'b0;
         end
         m_step_prev  = step;
         m_speed_prev = speed;
         m_mode_prev  = mode;
      end
   endtask

   // Advance the model on the same edge the DUT samples its inputs.
   always @(posedge clk) model_edge();

   // Compare DUT against the model half a cycle after every edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_frame", int'(frame), int'(exp_frame));
         check("model_tick", int'(frame_tick), int'(exp_tick));
      end
   end

   // ------------------------------------------------------------------------
   // Directed helpers
   // ------------------------------------------------------------------------
   // Wait (bounded) for the next frame_tick; n = negedges elapsed.
   task automatic wait_tick(input int max, output logic [N-1:0] f, output int n);
      bit got;
      got = 1'b0;
      n   = 0;
      f   = '0;
      while (!got && n < max) begin
         @(negedge clk);
         n++;
         if (frame_tick) begin
            got = 1'b1;
            f   = frame;
         end
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL tick_timeout: no frame_tick within %0d clk", max);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   // Directed scenarios
   // ------------------------------------------------------------------------
   initial begin
      logic [N-1:0] f;
      int n;
      int ticks;
      int exp1 [8] = '{'b1000, 'b1100, 'b1110, 'b1111, 'b1110, 'b1100, 'b1000, 'b0000};
      int exp2 [7] = '{'b0100, 'b0010, 'b0001, 'b0010, 'b0100, 'b1000, 'b0100};
      int exp3 [3] = '{'b0100, 'b0010, 'b0001};
      int got3 [3] = '{0, 0, 0};

      // 1: reset, fill-bounce at fast speed.
      rst = 1'b1; mode = 2'd0; speed = 2'd3; step = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_frame", int'(frame), 'b0000);
      check("reset_tick", int'(frame_tick), 0);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wait_tick(10, f, n);
         check("t1_frame", int'(f), exp1[k]);
         check("t1_gap", n, (k == 0) ? 1 : D_FAST);
      end

      // 2: ping-pong dot at mid speed; the change edge reloads a full period,
      // so the first tick appears D_MID clk after the edge that sees it.
      mode = 2'd2; speed = 2'd2;
      for (int k = 0; k < 7; k++) begin
         wait_tick(10, f, n);
         check("t2_frame", int'(f), exp2[k]);
         check("t2_gap", n, (k == 0) ? D_MID + 1 : D_MID);
      end

      // 3: stopped running dot, no ticks until stepped.
      mode = 2'd1; speed = 2'd0;
      ticks = 0;
      repeat (50) begin
         @(negedge clk);
         if (frame_tick) ticks++;
      end
      check("t3_idle_ticks", ticks, 0);
      for (int k = 0; k < 3; k++) begin
         step = 1'b1;
         repeat (3) begin
            @(negedge clk);
            if (frame_tick) begin
               if (ticks < 3) got3[ticks] = int'(frame);
               ticks++;
            end
         end
         step = 1'b0;
         repeat (3) begin
            @(negedge clk);
            if (frame_tick) ticks++;
         end
      end
      check("t3_step_ticks", ticks, 3);
      for (int k = 0; k < 3; k++) check("t3_step_frame", got3[k], exp3[k]);

      // 4: speed 2 -> 1 mid-count, then mode 1 -> 3 on an advance cycle.
      speed = 2'd2;
      wait_tick(10, f, n);
      check("t4_wrap_frame", int'(f), 'b1000);
      @(negedge clk);
      speed = 2'd1;
      wait_tick(20, f, n);
      check("t4_speed_change_gap", n, D_SLOW + 1);
      check("t4_after_change_frame", int'(f), 'b0100);
      repeat (D_SLOW - 1) @(negedge clk);
      mode = 2'd3;
      @(negedge clk);
      check("t4_mode_change_frame", int'(frame), 'b0000);
      check("t4_mode_change_tick", int'(frame_tick), 0);
      wait_tick(20, f, n);
      check("t4_blink_gap", n, D_SLOW);
      check("t4_blink_frame", int'(f), 'b1111);

      // 5: reset pulse at frame 1110 restarts fill-bounce.
      mode = 2'd0; speed = 2'd3;
      wait_tick(10, f, n);
      check("t5_first", int'(f), 'b1000);
      wait_tick(10, f, n);
      wait_tick(10, f, n);
      check("t5_pre_reset", int'(f), 'b1110);
      rst = 1'b1;
      @(negedge clk);
      check("t5_reset_frame", int'(frame), 'b0000);
      check("t5_reset_tick", int'(frame_tick), 0);
      rst = 1'b0;
      wait_tick(10, f, n);
      check("t5_restart_gap", n, 1);
      check("t5_restart_frame", int'(f), 'b1000);
      wait_tick(10, f, n);
      check("t5_restart_frame2", int'(f), 'b1100);

      // 6: blink at slow speed; step toggling is ignored while running.
      mode = 2'd3; speed = 2'd1;
      wait_tick(20, f, n);
      check("t6_first_gap", n, D_SLOW + 1);
      check("t6_first_frame", int'(f), 'b1111);
      for (int k = 0; k < 3; k++) begin
         step = (k == 0);
         @(negedge clk);
         check("t6_pulse_width", int'(frame_tick), 0);
         wait_tick(20, f, n);
         check("t6_gap", n, D_SLOW - 1);
         check("t6_frame", int'(f), (k % 2 == 0) ? 'b0000 : 'b1111);
      end

      step = 1'b0;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
